btn_conditioner: RTL

- Front-end stage that feeds the lock FSM.
- Takes the raw, active-low board push-buttons (toggle, enter, next) and synchronises and debounces each one on hw_clk.
- Emits clean single-cycle press, release and long-press pulses plus a debounced level per button.
- Replaces the slow-clock sampling in the lock FSM, so the whole design runs on hw_clk.

---
 rtl/lock_pkg.sv | 28 ++
 rtl/btn_debounce_ch.sv | 123 ++++++++++++
 rtl/btn_conditioner.sv | 44 ++++
 3 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and constants for the lock front end
//
// Purpose: channel FSM state encoding, button index map and default timing
//          for a 12 MHz hw_clk.
// Ports:   none (package).

package lock_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_e;

  // Board button positions within btn_raw / output vectors.
  localparam int BTN_TOGGLE = 0;
  localparam int BTN_ENTER  = 1;
  localparam int BTN_NEXT   = 2;

  localparam int NUM_BTN_DEFAULT = 3;

  // 20 ms and 2 s at 12 MHz.
  localparam int DEBOUNCE_CYCLES_12M = 240000;
  localparam int LONG_CYCLES_12M     = 24000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, debounce FSM, hold timer
//
// Purpose: turns one raw active-low button into a debounced level and
//          single-cycle press / release / long-press strobes.
// Ports:
//   hw_clk        in   system clock, rising edge
//   btn_reset     in   synchronous active-low reset
//   raw           in   raw button pin, 0 = pressed, asynchronous
//   level         out  debounced level, 1 = pressed
//   press_pulse   out  one-cycle strobe on accepted press
//   release_pulse out  one-cycle strobe on accepted release
//   long_pulse    out  one-cycle strobe when the hold reaches LONG_CYCLES

module btn_debounce_ch
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12M,
  parameter int LONG_CYCLES     = LONG_CYCLES_12M
) (
  input  logic hw_clk,
  input  logic btn_reset,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              sync_meta;
  logic              sync;
  btn_state_e        state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;

  always_ff @(posedge hw_clk) begin
    if (!btn_reset) begin
      // Synchroniser resets to "released" so a held button after reset
      // is seen as a fresh falling edge and fully debounced.
      sync_meta     <= 1'b1;
      sync          <= 1'b1;
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      sync_meta     <= raw;
      sync          <= sync_meta;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      // The hold timer runs in both held states so a bouncing release
      // neither pauses nor restarts the long-press measurement.
      if (state == PRESSED || state == DB_RELEASE) begin
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt <= hold_cnt + 1'b1;
        end else if (!long_done) begin
          long_pulse <= 1'b1;
          long_done  <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!sync) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
          end
        end

        DB_PRESS: begin
          if (sync) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state       <= PRESSED;
            level       <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (sync) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end
        end

        DB_RELEASE: begin
          if (!sync) begin
            state <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - synchronise and debounce the lock push-buttons on hw_clk
//
// Purpose: NUM_BTN independent button channels feeding the lock FSM.
// Ports:
//   hw_clk        in   system clock
//   btn_reset     in   synchronous active-low reset
//   btn_raw       in   [NUM_BTN] raw buttons, 0 = pressed
//   btn_level     out  [NUM_BTN] debounced level, 1 = pressed
//   press_pulse   out  [NUM_BTN] one-cycle press strobes
//   release_pulse out  [NUM_BTN] one-cycle release strobes
//   long_pulse    out  [NUM_BTN] one-cycle long-press strobes

module btn_conditioner
  import lock_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12M,
  parameter int LONG_CYCLES     = LONG_CYCLES_12M
) (
  input  logic               hw_clk,
  input  logic               btn_reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .hw_clk        (hw_clk),
      .btn_reset     (btn_reset),
      .raw           (btn_raw[i]),
      .level         (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule
